// File: rtl/tff_mode_counter.sv
// Mode-selectable counter built from a bank of T flip-flops (Q <= Q ^ T).
// Supports hold/up/down/load, a programmable wrap limit, terminal count and sticky wrap flag.
module tff_mode_counter #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             CLEAR_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] MAX,
    input  logic             CLR_WRAP,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T_VEC,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] up_t_s;
    logic [WIDTH-1:0] dn_t_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] t_vec_s;
    logic             up_wrap_s;
    logic             dn_wrap_s;
    logic             tc_s;

    // Ripple toggle chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_run;
        logic dn_run;
        up_t_s = '0;
        dn_t_s = '0;
        up_run = 1'b1;
        dn_run = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            up_t_s[i] = up_run;
            dn_t_s[i] = dn_run;
            up_run    = up_run & q_r[i];
            dn_run    = dn_run & ~q_r[i];
        end
    end

    // Wrap conditions; a Q above MAX (after a load or MAX change) wraps in either direction.
    always_comb begin
        up_wrap_s = (q_r >= MAX);
        dn_wrap_s = (q_r == '0) || (q_r > MAX);
    end

    // Next-state selection and terminal count.
    always_comb begin
        q_next_s = q_r;
        tc_s     = 1'b0;
        if (EN) begin
            case (MODE)
                MODE_HOLD: begin
                    q_next_s = q_r;
                end
                MODE_UP: begin
                    if (up_wrap_s) begin
                        q_next_s = '0;
                        tc_s     = 1'b1;
                    end else begin
                        q_next_s = q_r ^ up_t_s;
                    end
                end
                MODE_DOWN: begin
                    if (dn_wrap_s) begin
                        q_next_s = MAX;
                        tc_s     = 1'b1;
                    end else begin
                        q_next_s = q_r ^ dn_t_s;
                    end
                end
                MODE_LOAD: begin
                    q_next_s = D;
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
        end else begin
            q_next_s = q_r;
        end
        t_vec_s = q_r ^ q_next_s;
    end

    // Counter bank: every bit is a T flip-flop driven by its toggle enable.
    always_ff @(posedge CLK) begin
        if (!CLEAR_N) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= q_r ^ t_vec_s;
        end
    end

    // Sticky wrap flag; a wrap on the same edge as a clear request wins.
    always_ff @(posedge CLK) begin
        if (!CLEAR_N) begin
            wrap_r <= 1'b0;
        end else if (tc_s) begin
            wrap_r <= 1'b1;
        end else if (CLR_WRAP) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_r;
        end
    end

    assign Q     = q_r;
    assign WRAP  = wrap_r;
    assign T_VEC = t_vec_s;
    assign TC    = tc_s;

endmodule

// File: tb/tb_tff_mode_counter.sv
// Scoreboard bench for tff_mode_counter: an 8-bit instance and a 1-bit toggle-FF instance.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_tff_mode_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       clear_n_a, en_a, clr_a;
    logic [1:0] mode_a;
    logic [7:0] d_a, max_a;
    logic [7:0] q_a, tv_a;
    logic       tc_a, wrap_a;

    // 1-bit instance
    logic       clear_n_b, en_b, clr_b;
    logic [1:0] mode_b;
    logic [0:0] d_b, max_b;
    logic [0:0] q_b, tv_b;
    logic       tc_b, wrap_b;

    tff_mode_counter #(.WIDTH(8), .RESET_VAL(8'h05)) dut_a (
        .CLK(clk), .CLEAR_N(clear_n_a), .EN(en_a), .MODE(mode_a), .D(d_a), .MAX(max_a),
        .CLR_WRAP(clr_a), .Q(q_a), .T_VEC(tv_a), .TC(tc_a), .WRAP(wrap_a)
    );

    tff_mode_counter #(.WIDTH(1), .RESET_VAL(1'b0)) dut_b (
        .CLK(clk), .CLEAR_N(clear_n_b), .EN(en_b), .MODE(mode_b), .D(d_b), .MAX(max_b),
        .CLR_WRAP(clr_b), .Q(q_b), .T_VEC(tv_b), .TC(tc_b), .WRAP(wrap_b)
    );

    typedef struct {
        bit       sel_b;
        int       row;
        logic [7:0] q;
        logic       wrap;
        logic       tc;
        logic [7:0] tv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (!e.sel_b) begin
                cmp("q",     e.row, q_a, e.q);
                cmp("wrap",  e.row, {7'd0, wrap_a}, {7'd0, e.wrap});
                cmp("tc",    e.row, {7'd0, tc_a}, {7'd0, e.tc});
                cmp("t_vec", e.row, tv_a, e.tv);
            end else begin
                cmp("q1",     e.row, {7'd0, q_b}, e.q);
                cmp("wrap1",  e.row, {7'd0, wrap_b}, {7'd0, e.wrap});
                cmp("tc1",    e.row, {7'd0, tc_b}, {7'd0, e.tc});
                cmp("t_vec1", e.row, {7'd0, tv_b}, e.tv);
            end
        end
    end

    int row_n = 0;

    // After an edge: apply inputs for the coming edge and record what the outputs must show now.
    task automatic row_a(input logic cn, input logic en, input logic [1:0] m, input logic [7:0] d,
                         input logic [7:0] mx, input logic clr,
                         input logic [7:0] eq, input logic ew, input logic etc, input logic [7:0] etv);
        exp_t e;
        @(posedge clk);
        #1;
        clear_n_a = cn; en_a = en; mode_a = m; d_a = d; max_a = mx; clr_a = clr;
        e.sel_b = 1'b0; e.row = row_n; e.q = eq; e.wrap = ew; e.tc = etc; e.tv = etv;
        sb.push_back(e);
        row_n++;
    endtask

    task automatic row_b(input logic en, input logic eq, input logic ew, input logic etc, input logic etv);
        exp_t e;
        @(posedge clk);
        #1;
        clear_n_b = 1'b1; en_b = en; mode_b = 2'b01; max_b = 1'b1; clr_b = 1'b0;
        e.sel_b = 1'b1; e.row = row_n; e.q = {7'd0, eq}; e.wrap = ew; e.tc = etc; e.tv = {7'd0, etv};
        sb.push_back(e);
        row_n++;
    endtask

    initial begin
        clear_n_a = 1'b0; en_a = 1'b1; mode_a = 2'b01; d_a = 8'h00; max_a = 8'h03; clr_a = 1'b0;
        clear_n_b = 1'b0; en_b = 1'b0; mode_b = 2'b01; d_b = 1'b0; max_b = 1'b1; clr_b = 1'b0;

        //     cn    en    mode   d      max    clr  | Q      W     TC    T_VEC
        row_a(1'b0, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h05, 1'b0, 1'b1, 8'h05); // reset edge 1
        clear_n_b = 1'b1;
        row_a(1'b1, 1'b1, 2'b11, 8'h00, 8'h03, 1'b0,  8'h05, 1'b0, 1'b0, 8'h05); // reset edge 2, load 0
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h00, 1'b0, 1'b0, 8'h01); // up, MAX=3
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h01, 1'b0, 1'b0, 8'h03);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h02, 1'b0, 1'b0, 8'h01);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h03, 1'b0, 1'b1, 8'h03);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h00, 1'b1, 1'b0, 8'h01);
        row_a(1'b1, 1'b1, 2'b10, 8'h00, 8'h09, 1'b0,  8'h01, 1'b1, 1'b0, 8'h01); // down, MAX=9
        row_a(1'b1, 1'b1, 2'b10, 8'h00, 8'h09, 1'b0,  8'h00, 1'b1, 1'b1, 8'h09);
        row_a(1'b1, 1'b1, 2'b10, 8'h00, 8'h09, 1'b0,  8'h09, 1'b1, 1'b0, 8'h01);
        row_a(1'b1, 1'b1, 2'b11, 8'hF0, 8'h10, 1'b0,  8'h08, 1'b1, 1'b0, 8'hF8); // load beyond MAX
        row_a(1'b1, 1'b1, 2'b01, 8'hF0, 8'h10, 1'b0,  8'hF0, 1'b1, 1'b1, 8'hF0);
        row_a(1'b1, 1'b1, 2'b10, 8'hF0, 8'h10, 1'b0,  8'h00, 1'b1, 1'b1, 8'h10);
        row_a(1'b1, 1'b0, 2'b10, 8'h00, 8'h10, 1'b1,  8'h10, 1'b1, 1'b0, 8'h00); // clear with EN=0
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h10, 1'b1,  8'h10, 1'b0, 1'b1, 8'h10); // clear vs wrap
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h10, 1'b1,  8'h00, 1'b1, 1'b0, 8'h01);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0,  8'h01, 1'b0, 1'b1, 8'h01); // MAX=0
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0,  8'h00, 1'b1, 1'b1, 8'h00);
        row_a(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0,  8'h00, 1'b1, 1'b1, 8'h00);
        row_a(1'b1, 1'b1, 2'b11, 8'hFE, 8'hFF, 1'b0,  8'h00, 1'b1, 1'b0, 8'hFE); // full-range roll
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b1,  8'hFE, 1'b1, 1'b0, 8'h01);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b0,  8'hFF, 1'b0, 1'b1, 8'hFF);
        row_a(1'b0, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b0,  8'h00, 1'b1, 1'b0, 8'h01); // mid-count reset
        row_a(1'b1, 1'b0, 2'b01, 8'h00, 8'hFF, 1'b0,  8'h05, 1'b0, 1'b0, 8'h00);
        row_a(1'b1, 1'b1, 2'b01, 8'h00, 8'h03, 1'b0,  8'h05, 1'b0, 1'b1, 8'h05); // Q above new MAX
        row_a(1'b1, 1'b1, 2'b00, 8'h00, 8'h03, 1'b0,  8'h00, 1'b1, 1'b0, 8'h00); // hold
        row_a(1'b1, 1'b0, 2'b00, 8'h00, 8'h03, 1'b0,  8'h00, 1'b1, 1'b0, 8'h00);

        // 1-bit toggle flip-flop: EN pattern 1,1,0,1
        //    en    Q     W     TC    T_VEC
        row_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        row_b(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        row_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        row_b(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        row_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
